shift_issue_stage: RTL and testbench

- Two-stage pipeline directly upstream of the processor's combinational `barrel_shifter`.
- Accepts a MIPS R-type shift instruction word plus its register operands over a valid/ready handshake.
- Decodes the instruction into registered shifter controls (`in`, `sl`, direction, one-hot kind), captures the shifter's result one cycle later, and presents it with its destination register to writeback.

---
 rtl/shift_issue_stage.sv | 167 ++++++++++++++++
 tb/tb_shift_issue_stage.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// shift_issue_stage : decode MIPS R-type shifts, drive barrel_shifter, capture
// Revision: 1.0
// ----------------------------------------------------------------------------
module shift_issue_stage #(
  parameter int n = 31
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instr,
  input  logic [n:0]   rs_val,
  input  logic [n:0]   rt_val,
  output logic [n:0]   sh_in,
  output logic [4:0]   sh_sl,
  output logic         sh_left_or_right,
  output logic         sh_logic,
  output logic         sh_rotate,
  output logic         sh_arith,
  input  logic [n:0]   sh_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n:0]   out_data,
  output logic [4:0]   out_rd,
  output logic         out_wr_en,
  output logic         out_err
);

  localparam logic [5:0] c_f_sll  = 6'b000000;
  localparam logic [5:0] c_f_srl  = 6'b000010;
  localparam logic [5:0] c_f_sra  = 6'b000011;
  localparam logic [5:0] c_f_sllv = 6'b000100;
  localparam logic [5:0] c_f_srlv = 6'b000110;
  localparam logic [5:0] c_f_srav = 6'b000111;

  logic       w_legal;
  logic       w_right;
  logic       w_logic;
  logic       w_rotate;
  logic       w_arith;
  logic [4:0] w_sl;
  logic       w_s2_accept;
  logic       w_in_fire;
  logic       w_s1_fire;
  logic       w_unused;

  logic       r_s1_valid;
  logic [4:0] r_s1_rd;
  logic       r_s1_err;

  // rt field and the upper bits of rs are not needed by a shift decode
  assign w_unused = ^{instr[20:16], rs_val[n:5]};

  assign w_s2_accept = !out_valid || out_ready;
  assign in_ready    = !r_s1_valid || w_s2_accept;
  assign w_in_fire   = in_valid && in_ready;
  assign w_s1_fire   = r_s1_valid && w_s2_accept;

  // Illegal words leave every control at zero so the shifter sees no select
  always_comb begin
    w_legal  = 1'b0;
    w_right  = 1'b0;
    w_logic  = 1'b0;
    w_rotate = 1'b0;
    w_arith  = 1'b0;
    w_sl     = 5'd0;
    if (instr[31:26] == 6'd0) begin
      unique case (instr[5:0])
        c_f_sll: if (instr[25:21] == 5'd0) begin
          w_legal = 1'b1;
          w_logic = 1'b1;
          w_sl    = instr[10:6];
        end
        c_f_srl: if (instr[25:22] == 4'd0) begin
          w_legal  = 1'b1;
          w_right  = 1'b1;
          w_rotate = instr[21];
          w_logic  = !instr[21];
          w_sl     = instr[10:6];
        end
        c_f_sra: if (instr[25:21] == 5'd0) begin
          w_legal = 1'b1;
          w_right = 1'b1;
          w_arith = 1'b1;
          w_sl    = instr[10:6];
        end
        c_f_sllv: if (instr[10:6] == 5'd0) begin
          w_legal = 1'b1;
          w_logic = 1'b1;
          w_sl    = rs_val[4:0];
        end
        c_f_srlv: if (instr[10:7] == 4'd0) begin
          w_legal  = 1'b1;
          w_right  = 1'b1;
          w_rotate = instr[6];
          w_logic  = !instr[6];
          w_sl     = rs_val[4:0];
        end
        c_f_srav: if (instr[10:6] == 5'd0) begin
          w_legal = 1'b1;
          w_right = 1'b1;
          w_arith = 1'b1;
          w_sl    = rs_val[4:0];
        end
        default: w_legal = 1'b0;
      endcase
    end
  end

  // S1: shifter controls, cleared whenever the stage drains empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid       <= 1'b0;
      r_s1_rd          <= 5'd0;
      r_s1_err         <= 1'b0;
      sh_in            <= '0;
      sh_sl            <= 5'd0;
      sh_left_or_right <= 1'b0;
      sh_logic         <= 1'b0;
      sh_rotate        <= 1'b0;
      sh_arith         <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_valid       <= 1'b1;
      r_s1_rd          <= instr[15:11];
      r_s1_err         <= !w_legal;
      sh_in            <= w_legal ? rt_val : '0;
      sh_sl            <= w_sl;
      sh_left_or_right <= w_right;
      sh_logic         <= w_logic;
      sh_rotate        <= w_rotate;
      sh_arith         <= w_arith;
    end else if (w_s1_fire) begin
      r_s1_valid       <= 1'b0;
      r_s1_rd          <= 5'd0;
      r_s1_err         <= 1'b0;
      sh_in            <= '0;
      sh_sl            <= 5'd0;
      sh_left_or_right <= 1'b0;
      sh_logic         <= 1'b0;
      sh_rotate        <= 1'b0;
      sh_arith         <= 1'b0;
    end
  end

  // S2: sh_out is sampled only on the load edge, so stalls hold the result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= 5'd0;
      out_wr_en <= 1'b0;
      out_err   <= 1'b0;
    end else if (w_s1_fire) begin
      out_valid <= 1'b1;
      out_data  <= r_s1_err ? '0 : sh_out;
      out_rd    <= r_s1_rd;
      out_err   <= r_s1_err;
      out_wr_en <= !r_s1_err && (r_s1_rd != 5'd0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_issue_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_shift_issue_stage : scoreboard bench with a behavioural shifter/decoder
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_shift_issue_stage;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] sh_in;
  logic [4:0]  sh_sl;
  logic        sh_left_or_right;
  logic        sh_logic;
  logic        sh_rotate;
  logic        sh_arith;
  logic [31:0] sh_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wr_en;
  logic        out_err;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   rdy_rand = 1'b0;
  exp_t exp_q[$];
  int   pop_cyc[$];

  shift_issue_stage #(.n(31)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
    .sh_in(sh_in), .sh_sl(sh_sl), .sh_left_or_right(sh_left_or_right),
    .sh_logic(sh_logic), .sh_rotate(sh_rotate), .sh_arith(sh_arith),
    .sh_out(sh_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_wr_en(out_wr_en), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Bit-by-bit shifter; no/multiple selects yield a deliberately nonzero junk word
  function automatic logic [31:0] shifter(input logic [31:0] d, input logic [4:0] sl,
                                          input logic r, input logic lg, input logic ro,
                                          input logic ar);
    logic [31:0] res;
    int s;
    if ((32'(lg) + 32'(ro) + 32'(ar)) != 1) return ~d ^ 32'h5A5A_A5A5;
    for (int i = 0; i < 32; i++) begin
      s = r ? i + int'(sl) : i - int'(sl);
      if (ro) res[i] = d[(s + 32) % 32];
      else if (s >= 0 && s < 32) res[i] = d[s];
      else res[i] = ar & d[31];
    end
    return res;
  endfunction

  always_comb sh_out = shifter(sh_in, sh_sl, sh_left_or_right, sh_logic, sh_rotate, sh_arith);

  // Architectural result of one instruction, straight from the ISA rules
  function automatic exp_t ref_model(input logic [31:0] i, input logic [31:0] rs,
                                     input logic [31:0] rt);
    exp_t e;
    bit legal = 0;
    int kind = 0;
    int amt = 0;
    logic [63:0] dbl;
    if (i[31:26] == 0) begin
      case (i[5:0])
        6'd0: if (i[25:21] == 0) begin legal = 1; kind = 0; amt = i[10:6]; end
        6'd2: if (i[25:22] == 0) begin legal = 1; kind = i[21] ? 2 : 1; amt = i[10:6]; end
        6'd3: if (i[25:21] == 0) begin legal = 1; kind = 3; amt = i[10:6]; end
        6'd4: if (i[10:6] == 0) begin legal = 1; kind = 0; amt = rs[4:0]; end
        6'd6: if (i[10:7] == 0) begin legal = 1; kind = i[6] ? 2 : 1; amt = rs[4:0]; end
        6'd7: if (i[10:6] == 0) begin legal = 1; kind = 3; amt = rs[4:0]; end
        default: legal = 0;
      endcase
    end
    dbl = {rt, rt} >> amt;
    case (kind)
      0: e.data = rt << amt;
      1: e.data = rt >> amt;
      2: e.data = dbl[31:0];
      default: e.data = $signed(rt) >>> amt;
    endcase
    if (!legal) e.data = 32'd0;
    e.rd  = i[15:11];
    e.err = !legal;
    e.wr  = legal && (i[15:11] != 0);
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [5:0] f;
    logic [4:0] rs, sa;
    logic [31:0] w;
    int pick;
    if ($urandom_range(0, 9) == 0) return $urandom;
    pick = $urandom_range(0, 5);
    case (pick)
      0: f = 6'd0; 1: f = 6'd2; 2: f = 6'd3; 3: f = 6'd4; 4: f = 6'd6; default: f = 6'd7;
    endcase
    rs = 5'($urandom);
    sa = 5'($urandom);
    if (f < 6'd4) rs = (f == 6'd2) ? {4'd0, rs[0]} : 5'd0;
    else sa = (f == 6'd6) ? {4'd0, sa[0]} : 5'd0;
    w = {6'd0, rs, 5'($urandom), 5'($urandom), sa, f};
    if ($urandom_range(0, 9) == 0) w[$urandom_range(6, 25)] ^= 1'b1;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one instruction; the expectation is queued on the cycle it is accepted
  task automatic issue(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    in_valid = 1'b1;
    instr    = i;
    rs_val   = rs;
    rt_val   = rt;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ref_model(i, rs, rt));
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL issue_timeout: got no accept expected accept within 50 cycles");
    in_valid = 1'b0;
  endtask

  task automatic chk_sh(input string name, input logic [4:0] sl, input logic r,
                        input logic [2:0] sel, input logic [31:0] d);
    chk({name, "_sl"}, 32'(sh_sl), 32'(sl));
    chk({name, "_dir"}, 32'(sh_left_or_right), 32'(r));
    chk({name, "_sel"}, 32'({sh_logic, sh_rotate, sh_arith}), 32'(sel));
    chk({name, "_in"}, sh_in, d);
  endtask

  // Monitor: scoreboard pops, stall stability and shifter-drive invariants
  initial begin
    exp_t e;
    bit prev_stall = 0;
    bit prev_full = 0;
    logic [31:0] s_data, s_in;
    logic [4:0]  s_rd, s_sl;
    logic [3:0]  s_flags;
    logic [3:0]  s_sel;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_stall = 0;
        prev_full  = 0;
      end else begin
        chk("sel_onehot", 32'($countones({sh_logic, sh_rotate, sh_arith}) <= 1), 32'd1);
        if ({sh_logic, sh_rotate, sh_arith} == 3'b000) begin
          chk("idle_sh_in", sh_in, 32'd0);
          chk("idle_sh_sl", 32'(sh_sl), 32'd0);
        end
        if (prev_stall) begin
          chk("hold_out", {out_data ^ s_data}, 32'd0);
          chk("hold_meta", 32'({out_valid, out_rd, out_wr_en, out_err}),
              32'({1'b1, s_rd, s_flags[1:0]}));
        end
        if (prev_full) begin
          chk("hold_sh_in", sh_in, s_in);
          chk("hold_sh_ctl", 32'({sh_sl, sh_left_or_right, sh_logic, sh_rotate, sh_arith}),
              32'({s_sl, s_sel}));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got rd=%0d data=%h expected none", out_rd, out_data);
          end else begin
            e = exp_q.pop_front();
            pop_cyc.push_back(cyc);
            chk("out_data", out_data, e.data);
            chk("out_rd", 32'(out_rd), 32'(e.rd));
            chk("out_wr_en", 32'(out_wr_en), 32'(e.wr));
            chk("out_err", 32'(out_err), 32'(e.err));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_full  = prev_stall && !in_ready;
        s_data  = out_data;
        s_rd    = out_rd;
        s_flags = {2'b00, out_wr_en, out_err};
        s_in    = sh_in;
        s_sl    = sh_sl;
        s_sel   = {sh_left_or_right, sh_logic, sh_rotate, sh_arith};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      if (rdy_rand) out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; rs_val = '0; rt_val = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sh", 32'({sh_logic, sh_rotate, sh_arith, sh_left_or_right, sh_sl}), 32'd0);
    chk("rst_out", 32'({out_rd, out_wr_en, out_err}) | out_data, 32'd0);
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    issue(32'h0002_1900, 32'd0, 32'h0000_0001);
    chk_sh("sll", 5'd4, 1'b0, 3'b100, 32'h1);
    @(posedge clk); #1;
    chk("sll_valid", 32'(out_valid), 32'd1);
    chk("sll_data", out_data, 32'h10);
    chk("sll_meta", 32'({out_rd, out_wr_en, out_err}), 32'({5'd3, 1'b1, 1'b0}));

    issue(32'h00E6_2807, 32'h0000_0124, 32'h8000_0000);
    chk_sh("srav", 5'd4, 1'b1, 3'b001, 32'h8000_0000);
    issue(32'h0022_0A02, 32'd0, 32'h1234_5678);
    chk_sh("rotr", 5'd8, 1'b1, 3'b010, 32'h1234_5678);
    @(posedge clk); #1;
    chk("rotr_data", out_data, 32'h7812_3456);

    issue(32'h8C00_0000, 32'd5, 32'd7);
    chk_sh("lw", 5'd0, 1'b0, 3'b000, 32'd0);
    @(posedge clk); #1;
    chk("lw_meta", 32'({out_wr_en, out_err}), 32'b01);
    chk("lw_data", out_data, 32'd0);
    issue(32'h0000_0000, 32'd0, 32'h0000_ABCD);
    @(posedge clk); #1;
    chk("nop_meta", 32'({out_wr_en, out_err}), 32'b00);

    // Backpressure: two accepted, third blocked until writeback accepts
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(32'h0003_0840, 32'd0, 32'h0000_0003);
    issue(32'h0003_1080, 32'd0, 32'h0000_0005);
    in_valid = 1'b1;
    instr = 32'h0003_18C0;
    rt_val = 32'h0000_0007;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(32'h0003_18C0, 32'd0, 32'h0000_0007);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_consec", 32'(pop_cyc[$] - pop_cyc[$-2]), 32'd2);

    // Reset with both stages full
    out_ready = 1'b0;
    issue(32'h0003_2100, 32'd0, 32'h0000_0009);
    issue(32'h0003_2940, 32'd0, 32'h0000_000B);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_sel", 32'({sh_logic, sh_rotate, sh_arith}), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("mrst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    rdy_rand = 1'b1;
    for (int k = 0; k < 300; k++) begin
      issue(gen_instr(), $urandom, $urandom);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
